// File: rtl/cb_config_sequencer.sv
// Config-bus sequencer for one connection box: one write or read
// outstanding, config_en held WRITE_CYCLES edges, reads after READ_LATENCY.
module cb_config_sequencer #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int WRITE_CYCLES = 2,
  parameter int READ_LATENCY = 1,
  parameter int COUNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_write,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic [DATA_W-1:0]  req_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic [ADDR_W-1:0]  config_addr,
  output logic [DATA_W-1:0]  config_data,
  output logic               config_en,
  input  logic [DATA_W-1:0]  read_data,
  output logic               busy,
  output logic [COUNT_W-1:0] write_count
);

  if (WRITE_CYCLES < 1 || WRITE_CYCLES > 16 ||
      READ_LATENCY < 1 || READ_LATENCY > 15) begin : g_bad_param
    $error("cb_config_sequencer: parameter out of range");
  end

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RD_WAIT,
    RESP
  } state_e;

  localparam logic [3:0] WR_LOAD = 4'(WRITE_CYCLES - 1);
  localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [COUNT_W-1:0] WC_MAX = '1;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  data_q;
  logic               en_q;
  logic               rvld_q;
  logic [DATA_W-1:0]  rdat_q;
  logic [COUNT_W-1:0] wcnt_q;

  assign req_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign config_addr = addr_q;
  assign config_data = data_q;
  assign config_en   = en_q;
  assign rsp_valid   = rvld_q;
  assign rsp_data    = rdat_q;
  assign write_count = wcnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      en_q    <= 1'b0;
      rvld_q  <= 1'b0;
      rdat_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            addr_q <= req_addr;
            if (req_write) begin
              data_q  <= req_data;
              en_q    <= 1'b1;
              cnt_q   <= WR_LOAD;
              state_q <= WRITE;
            end else begin
              cnt_q   <= RD_LOAD;
              state_q <= RD_WAIT;
            end
          end
        end
        WRITE: begin
          if (cnt_q == 4'd0) begin
            en_q    <= 1'b0;
            data_q  <= '0;
            state_q <= IDLE;
            if (wcnt_q != WC_MAX) wcnt_q <= wcnt_q + COUNT_W'(1);
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RD_WAIT: begin
          if (cnt_q == 4'd0) begin
            rdat_q  <= read_data;
            rvld_q  <= 1'b1;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rvld_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cb_config_sequencer.sv
// Bench for cb_config_sequencer: cb register-file model on the config bus,
// directed vector table, reset corners and randomized transactions.
module tb_cb_config_sequencer;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WC = 2;
  localparam int RL = 1;
  localparam int CW = 4;
  localparam int WMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] config_addr;
  logic [DW-1:0] config_data;
  logic          config_en;
  logic [DW-1:0] read_data;
  logic          busy;
  logic [CW-1:0] write_count;

  cb_config_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .WRITE_CYCLES(WC),
    .READ_LATENCY(RL), .COUNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .config_addr(config_addr), .config_data(config_data),
    .config_en(config_en), .read_data(read_data),
    .busy(busy), .write_count(write_count)
  );

  always #5 clk = ~clk;

  // cb model: 16 config registers, register 0 drives the output mux
  logic [31:0] cb_mem [16] = '{default: 32'h0};
  always @(posedge clk) begin
    if (config_en) cb_mem[config_addr[3:0]] <= config_data;
  end
  assign read_data = cb_mem[config_addr[3:0]];

  int en_hi = 0;
  always @(posedge clk) begin
    if (config_en) en_hi <= en_hi + 1;
  end

  function automatic logic [31:0] cb_in(input int i);
    return (i == 9) ? 32'd345 : 32'(i * 4);
  endfunction

  function automatic logic [31:0] cb_out();
    logic [31:0] r;
    int sel;
    r = cb_mem[0];
    sel = int'(r[3:0]);
    if (sel >= 10) return {16'h0, r[31:16]};
    if (sel >= 8) return cb_in(sel + 1);
    return cb_in(sel);
  endfunction

  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [16] = '{default: 32'h0};
  int n_wr = 0;

  function automatic int wc_exp();
    return (n_wr > WMAX) ? WMAX : n_wr;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Presents a request and returns at the first negedge after accept.
  task automatic start_accept(input bit wr, input logic [31:0] a,
                              input logic [31:0] d);
    int n;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_data  = d;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("ready_timeout", 0, 1);
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_data  = $urandom;
  endtask

  task automatic do_txn(input bit wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp,
                        input int hold);
    int n;
    logic [31:0] held;
    start_accept(wr, a, d);
    if (wr) begin
      n = 0;
      while (config_en && n < 40) begin
        chk("wr_addr", config_addr, a);
        chk("wr_data", config_data, d);
        chk("wr_busy", {busy, req_ready}, 2'b10);
        n++;
        @(negedge clk);
      end
      chk("wr_cycles", n, WC);
      ref_mem[a[3:0]] = d;
      n_wr++;
      chk("wr_data_zero", config_data, 0);
      chk("wr_count", write_count, wc_exp());
      chk("wr_idle", req_ready, 1);
    end else begin
      n = 0;
      while (!rsp_valid && n < 40) begin
        chk("rd_en_low", {config_en, config_data}, 0);
        chk("rd_addr", config_addr, a);
        @(negedge clk);
        n++;
      end
      chk("rd_latency", n, RL);
      chk("rd_data", rsp_data, exp);
      held = rsp_data;
      repeat (hold) begin
        @(negedge clk);
        chk("rsp_hold", {rsp_valid, req_ready}, 2'b10);
        chk("rsp_stable", rsp_data, held);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("rsp_done", {rsp_valid, req_ready}, 2'b01);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst_async", {config_en, rsp_valid, busy}, 0);
    chk("rst_count", write_count, 0);
    n_wr = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_release", {req_ready, config_en, rsp_valid}, 3'b100);
    chk("rst_release_wc", write_count, 0);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    bit          chk_out;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int e0;
    logic [31:0] a;
    logic [31:0] d;
    bit wr;

    vecs[0] = '{1'b1, 32'd0, 32'h1,       32'd4,       1'b1};
    vecs[1] = '{1'b1, 32'd0, 32'h8,       32'd345,     1'b1};
    vecs[2] = '{1'b1, 32'd0, 32'h7000A,   32'd7,       1'b1};
    vecs[3] = '{1'b0, 32'd0, 32'h0,       32'h7000A,   1'b0};
    vecs[4] = '{1'b1, 32'd5, 32'hDEADBEEF, 32'h0,      1'b0};
    vecs[5] = '{1'b0, 32'd5, 32'h0,       32'hDEADBEEF, 1'b0};
    vecs[6] = '{1'b0, 32'd3, 32'h0,       32'h0,       1'b0};

    repeat (3) @(negedge clk);
    chk("init_state", {config_en, rsp_valid, busy}, 0);
    chk("init_regs", {config_addr, config_data}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("init_ready", req_ready, 1);

    // reset while a read is waiting for its data
    start_accept(1'b0, 32'd2, 32'h0);
    chk("mid_busy", busy, 1);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      do_txn(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].exp,
             vecs[i].wr ? 0 : 5);
      if (vecs[i].chk_out) chk($sformatf("cb_out%0d", i), cb_out(),
                               vecs[i].exp);
    end
    chk("tbl_count", write_count, 4);

    // reset in the second cycle of a write
    start_accept(1'b1, 32'd7, 32'h55);
    @(negedge clk);
    chk("w2_en", config_en, 1);
    ref_mem[7] = 32'h55;
    do_reset();
    chk("w2_cb_en", en_hi > 0, 1);
    do_txn(1'b1, 32'd7, 32'h66, 32'h0, 0);
    chk("w2_after", write_count, 1);
    do_txn(1'b0, 32'd7, 32'h0, 32'h66, 1);

    // saturation: 20 writes after reset
    do_reset();
    e0 = en_hi;
    for (int i = 0; i < 20; i++)
      do_txn(1'b1, 32'(i % 16), 32'(i * 3 + 1), 32'h0, 0);
    chk("sat_count", write_count, WMAX);
    chk("sat_pulses", en_hi - e0, 20 * WC);

    // reset while a response is pending
    start_accept(1'b0, 32'd1, 32'h0);
    @(negedge clk);
    chk("resp_pend", rsp_valid, 1);
    do_reset();

    for (int i = 0; i < 80; i++) begin
      wr = 1'($urandom);
      a  = $urandom;
      d  = $urandom;
      do_txn(wr, a, d, ref_mem[a[3:0]], $urandom_range(0, 3));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    chk("rand_count", write_count, wc_exp());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
